// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-entry instruction queue, redirect and optional stats
//   clk, rst         : clock, asynchronous active-high reset
//   imem_addr/data   : word address out (= pc), instruction word back in the same cycle
//   redirect/_pc     : downstream redirect request and target word address
//   id_ready         : decode accepts the head entry this cycle
//   id_valid/instr/pc: head entry of the instruction queue
//   fetch_cnt        : pushes since reset, saturating (only when FETCH_STATS_EN is defined)
//   stall_cnt        : cycles spent in FULL, saturating (only when FETCH_STATS_EN is defined)
`ifndef ISIZE
`define ISIZE 8
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module fetch_stage #(
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [`ISIZE-1:0] imem_addr,
    input  logic [`DSIZE-1:0] imem_data,
    input  logic              redirect,
    input  logic [`ISIZE-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [`DSIZE-1:0] id_instr,
    output logic [`ISIZE-1:0] id_pc,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
);
    typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;
    state_t            state, state_n;
    logic [`ISIZE-1:0] pc, pc_n;
    logic [1:0]        count, count_n, wr;
    logic [`ISIZE-1:0] q_pc [QDEPTH];
    logic [`DSIZE-1:0] q_instr [QDEPTH];
    logic              pop, push;

    assign imem_addr = pc;
    assign id_valid  = count != 2'd0;
    assign id_pc     = q_pc[0];
    assign id_instr  = q_instr[0];

    // Entry 0 is always the head; a pop shifts entry 1 down, so the write slot is count minus pop.
    always_comb begin
        pop     = id_valid & id_ready & ~redirect;
        push    = (state != BOOT) & ~redirect & ((count != 2'(QDEPTH)) | pop);
        count_n = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        pc_n    = redirect ? redirect_pc : push ? pc + 1'b1 : pc;
        wr      = count - {1'b0, pop};
        state_n = (redirect || state == BOOT) ? FETCH :
                  (count_n == 2'(QDEPTH) && !pop) ? FULL : FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= '0;
            count      <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            count <= count_n;
            if (pop) begin
                q_pc[0]    <= q_pc[1];
                q_instr[0] <= q_instr[1];
            end
            if (push) begin
                q_pc[wr[0]]    <= pc;
                q_instr[wr[0]] <= imem_data;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (state == FULL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a queue-level reference model
`ifndef ISIZE
`define ISIZE 8
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module tb_fetch_stage;
    localparam int MSIZE = 1 << `ISIZE;
    logic              clk = 0, rst = 1, redirect = 0, id_ready = 1;
    logic [`ISIZE-1:0] imem_addr, redirect_pc = '0, id_pc;
    logic [`DSIZE-1:0] imem_data, id_instr;
    logic              id_valid;
    logic [15:0]       fetch_cnt, stall_cnt;
    logic [`DSIZE-1:0] mem [MSIZE];
    int                checks = 0, errors = 0;

    fetch_stage #(.QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    initial begin
        for (int i = 0; i < MSIZE; i++) mem[i] = 32'hA500_0000 + i;
        mem[0] = 32'h00000000;
        mem[1] = 32'h05031000;
        mem[2] = 32'h00430800;
        mem[6] = 32'h18E40001;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched (pc, instr) pairs, advanced by the rules of the fetch stage.
    logic [`ISIZE-1:0] m_qpc [$];
    logic [`DSIZE-1:0] m_qin [$];
    logic [`ISIZE-1:0] m_pc;
    bit                m_boot, m_full;
    logic [15:0]       m_fetch, m_stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_qpc.delete(); m_qin.delete();
            m_pc = '0; m_boot = 1; m_full = 0; m_fetch = 0; m_stall = 0;
        end else begin
            bit pop;
            pop = m_qpc.size() != 0 && id_ready;
            if (m_full && m_stall != 16'hFFFF) m_stall++;
            if (redirect) begin
                m_qpc.delete(); m_qin.delete();
                m_pc = redirect_pc; m_boot = 0; m_full = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else begin
                int sz;
                sz = m_qpc.size();
                if (pop) begin
                    void'(m_qpc.pop_front()); void'(m_qin.pop_front());
                end
                if (sz < 2 || pop) begin
                    m_qpc.push_back(m_pc); m_qin.push_back(mem[m_pc]);
                    m_pc = m_pc + 1'b1;
                    if (m_fetch != 16'hFFFF) m_fetch++;
                end
                m_full = m_qpc.size() == 2 && !pop;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid", id_valid, m_qpc.size() != 0);
        chk("cmp_imem_addr", imem_addr, m_pc);
        if (m_qpc.size() != 0) begin
            chk("cmp_id_pc", id_pc, m_qpc[0]);
            chk("cmp_id_instr", id_instr, m_qin[0]);
        end
`ifdef FETCH_STATS_EN
        chk("cmp_fetch_cnt", fetch_cnt, m_fetch);
        chk("cmp_stall_cnt", stall_cnt, m_stall);
`else
        chk("cmp_fetch_cnt", fetch_cnt, 0);
        chk("cmp_stall_cnt", stall_cnt, 0);
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 6 && !id_valid; i++) step();
        chk(name, id_valid, 1);
    endtask

    initial begin
        logic [15:0] s0;
        repeat (3) step();
        rst = 0;
        chk("boot_valid0", id_valid, 0);
        wait_valid("boot_wait");
        chk("boot_pc0", id_pc, 0);
        chk("boot_in0", id_instr, 32'h00000000);
        step();
        chk("boot_pc1", id_pc, 1);
        chk("boot_in1", id_instr, 32'h05031000);
        step();
        chk("boot_pc2", id_pc, 2);
        chk("boot_in2", id_instr, 32'h00430800);

        redirect = 1; redirect_pc = 0; id_ready = 0;
        step();
        redirect = 0;
        chk("bp_flush", id_valid, 0);
        s0 = stall_cnt;
        repeat (5) step();
        chk("bp_pc", id_pc, 0);
        chk("bp_addr", imem_addr, 2);
        chk("bp_valid", id_valid, 1);
`ifdef FETCH_STATS_EN
        chk("bp_stall", stall_cnt - s0, 3);
`endif

        id_ready = 1;
        step();
        id_ready = 0;
        chk("pp_pc", id_pc, 1);
        chk("pp_addr", imem_addr, 3);
        step();
        chk("pp_hold_pc", id_pc, 1);
        chk("pp_hold_in", id_instr, 32'h05031000);

        redirect = 1; redirect_pc = 6; id_ready = 1;
        step();
        redirect = 0;
        chk("rd_valid0", id_valid, 0);
        step();
        chk("rd_valid1", id_valid, 1);
        chk("rd_pc6", id_pc, 6);
        chk("rd_in6", id_instr, 32'h18E40001);
        step();
        chk("rd_pc7", id_pc, 7);

        redirect = 1; redirect_pc = `ISIZE'(MSIZE - 1);
        step();
        redirect = 0;
        step();
        chk("wr_top", id_pc, MSIZE - 1);
        step();
        chk("wr_0", id_pc, 0);
        step();
        chk("wr_1", id_pc, 1);

        id_ready = 0;
        repeat (4) step();
        rst = 1;
        #1;
        chk("ar_valid", id_valid, 0);
        chk("ar_addr", imem_addr, 0);
        chk("ar_pc", id_pc, 0);
        chk("ar_instr", id_instr, 0);
        chk("ar_fetch", fetch_cnt, 0);
        chk("ar_stall", stall_cnt, 0);
        step();
        step();
        rst = 0; id_ready = 1;
        wait_valid("ar_wait");
        chk("ar_pc0", id_pc, 0);
        step();
        chk("ar_pc1", id_pc, 1);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, instruction queue depth (legal values 2 only).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_addr  output  `ISIZE  word address to instruction memory; equals pc.
REQ-005 SHALL have port imem_data  input  `DSIZE  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-006 SHALL have port redirect  input  1  branch/jump redirect request from downstream.
REQ-007 SHALL have port redirect_pc  input  `ISIZE  redirect target word address.
REQ-008 SHALL have port id_ready  input  1  decode accepts the head entry this cycle.
REQ-009 SHALL have port id_valid  output  1  head entry valid.
REQ-010 SHALL have port id_instr  output  `DSIZE  head instruction.
REQ-011 SHALL have port id_pc  output  `ISIZE  address of the head instruction.
REQ-012 SHALL have port fetch_cnt  output  16  instructions pushed since reset (stats).
REQ-013 SHALL have port stall_cnt  output  16  cycles in state FULL (stats).

Function
REQ-014 SHALL implement states BOOT, FETCH, FULL; BOOT->FETCH unconditionally one cycle after reset release (imem is loaded while rst is high).
REQ-015 SHALL perform no push in BOOT.
REQ-016 SHALL push {pc, imem_data} and set pc to pc+1 in any cycle where state is not BOOT, redirect=0, and (count<2 or a pop occurs in the same cycle).
REQ-017 SHALL pop the head when id_valid=1 and id_ready=1; id_valid = (count!=0); id_instr/id_pc show the head combinationally from registers.
REQ-018 SHALL, when full and popping in the same cycle, push and pop together, leaving count at 2.
REQ-019 SHALL enter FULL when count becomes 2 without a pop, and return to FETCH on the cycle a pop occurs.
REQ-020 SHALL give redirect highest priority: queue flushed (count=0), pc<=redirect_pc, no push that cycle, state FETCH (redirect during BOOT also sets pc and leaves BOOT), and the pop is discarded.
REQ-021 SHALL deliver the redirect_pc instruction on id_* with id_valid=1 exactly two cycles after redirect is sampled (push in the cycle after, visible after the following edge).
REQ-022 SHALL wrap pc from 2^`ISIZE-1 to 0 with no error indication.
REQ-023 SHALL keep id_instr/id_pc stable while id_valid=1 and id_ready=0.
REQ-024 SHALL saturate fetch_cnt and stall_cnt at 16'hFFFF.

Reset
REQ-025 SHALL, while rst=1, asynchronously force pc=0, count=0, state=BOOT, id_valid=0, id_instr=0, id_pc=0, fetch_cnt=0, stall_cnt=0, including mid-operation.
REQ-026 SHALL drive imem_addr=0 throughout reset.

Configuration
REQ-027 SHALL compile the statistics counters only when FETCH_STATS_EN is defined; without it fetch_cnt and stall_cnt SHALL be constant 0 and no counter flops exist.

Verification
REQ-028 SHALL verify boot: rst high 3 cycles, release, id_ready=1 -> cycle 1 id_valid=0, then id_pc=0,1,2,... with id_instr=32'h00000000, 32'h05031000, 32'h00430800, one per cycle.
REQ-029 SHALL verify backpressure: id_ready=0 for 5 cycles after first valid -> count reaches 2, imem_addr holds at 2, id_pc stays 0, stall_cnt increments per FULL cycle (with FETCH_STATS_EN).
REQ-030 SHALL verify simultaneous push/pop when full: release id_ready for one cycle -> id_pc advances 0->1, count stays 2, pc advances by 1.
REQ-031 SHALL verify redirect: redirect=1, redirect_pc=6 while entries are queued -> id_valid=0 next cycle, then id_pc=6, id_instr=32'h18E40001, id_pc=7 follows; queued entries never appear.
REQ-032 SHALL verify wrap: redirect_pc=2^`ISIZE-1 -> id_pc sequence 2^`ISIZE-1, 0, 1.
REQ-033 SHALL verify asynchronous reset mid-stream: assert rst between edges while full -> id_valid and counters zero immediately, BOOT sequence restarts from pc 0.
